// File: rtl/sram_resp.sv
// SRAM-style responder: word-organised RAM at ADDR_BASE with byte-enable writes and 1-cycle registered read.
// Optional request counters are built when SRAM_RESP_STAT_EN is defined.
module sram_resp #(
   parameter logic [31:0] ADDR_BASE  = 32'h1c00_0000,
   parameter int          DEPTH_LOG2 = 14
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        sram_en,
   input  logic [3:0]  sram_we,
   input  logic [31:0] sram_addr,
   input  logic [31:0] sram_wdata,
   output logic [31:0] sram_rdata,
   output logic        addr_err,
   output logic [31:0] rd_cnt,
   output logic [31:0] wr_cnt
);

   localparam int DEPTH = 1 << DEPTH_LOG2;

   // Handshake: sram_en is a valid with an implicit, always-high ready. Every
   // cycle with sram_en=1 and reset=0 is exactly one accepted request.
   logic                  accept;
   logic                  is_write;
   logic [31:0]           offset;
   logic                  in_range;
   logic [DEPTH_LOG2-1:0] word_idx;
   logic                  unused_offset_bits;

   logic [31:0] mem [0:DEPTH-1];

   assign accept   = sram_en && !reset;
   assign is_write = (sram_we != 4'b0000);

   // Wrapping subtraction means addresses below the base land far above the window.
   assign offset   = sram_addr - ADDR_BASE;
   assign in_range = (offset[31:DEPTH_LOG2+2] == '0);
   assign word_idx = offset[DEPTH_LOG2+1:2];

   assign unused_offset_bits = ^offset[1:0];

   always_ff @(posedge clk) begin
      if (accept && in_range) begin
         for (int b = 0; b < 4; b++) begin
            if (sram_we[b]) begin
               mem[word_idx][8*b +: 8] <= sram_wdata[8*b +: 8];
            end
         end
      end
   end

   // Read-first; with en=0 the registered data holds for a stalled requester.
   always_ff @(posedge clk) begin
      if (reset) begin
         sram_rdata <= 32'h0;
         addr_err   <= 1'b0;
      end else if (sram_en) begin
         if (in_range) begin
            sram_rdata <= mem[word_idx];
         end else begin
            sram_rdata <= 32'h0;
            addr_err   <= 1'b1;
         end
      end
   end

`ifdef SRAM_RESP_STAT_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_cnt <= 32'h0;
         wr_cnt <= 32'h0;
      end else if (accept) begin
         if (is_write) begin
            wr_cnt <= wr_cnt + 32'd1;
         end else begin
            rd_cnt <= rd_cnt + 32'd1;
         end
      end
   end
`else
   logic unused_stat;
   assign unused_stat = is_write;
   assign rd_cnt      = 32'h0;
   assign wr_cnt      = 32'h0;
`endif

endmodule
